// File: rtl/microblaze_soc.sv
// microblaze_soc: LED controller that boots dark, runs a lamp test, then bounces a one-hot chaser forever
// Ports:
//   clk    - system clock, all state updates on its rising edge
//   reset_ - synchronous reset, active-high; restarts the whole boot sequence
//   led    - registered 8-bit LED drive, 1 = LED on
module microblaze_soc #(
    parameter int BOOT_CYCLES = 16,
    parameter int TICK_CYCLES = 64
) (
    input  logic       clk,
    input  logic       reset_,
    output logic [7:0] led
);
    localparam int BW = BOOT_CYCLES > 1 ? $clog2(BOOT_CYCLES) : 1;
    localparam int TW = $clog2(TICK_CYCLES);
    localparam logic [BW-1:0] BOOT_LAST = BW'(BOOT_CYCLES - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
    typedef enum logic [1:0] {BOOT, LAMP, RUN} state_t;
    state_t state, state_n;
    logic [BW-1:0] boot_cnt, boot_cnt_n;
    logic [TW-1:0] tick_cnt, tick_cnt_n;
    logic dir, dir_n;
    logic [7:0] led_n, shifted;
    logic tick_done, boot_done;
    always_ff @(posedge clk) begin
        if (reset_) begin
            state    <= BOOT;
            boot_cnt <= '0;
            tick_cnt <= '0;
            dir      <= 1'b0;
            led      <= 8'h00;
        end else begin
            state    <= state_n;
            boot_cnt <= boot_cnt_n;
            tick_cnt <= tick_cnt_n;
            dir      <= dir_n;
            led      <= led_n;
        end
    end
    // dir: 0 shifts toward the MSB, 1 toward the LSB; it flips on reaching either end
    always_comb begin
        state_n    = state;
        boot_cnt_n = boot_cnt;
        tick_cnt_n = tick_cnt;
        dir_n      = dir;
        led_n      = led;
        boot_done  = boot_cnt == BOOT_LAST;
        tick_done  = tick_cnt == TICK_LAST;
        shifted    = dir ? led >> 1 : led << 1;
        case (state)
            BOOT: begin
                boot_cnt_n = boot_done ? '0 : boot_cnt + 1'b1;
                if (boot_done) begin
                    led_n      = 8'hff;
                    tick_cnt_n = '0;
                    state_n    = LAMP;
                end
            end
            LAMP: begin
                tick_cnt_n = tick_done ? '0 : tick_cnt + 1'b1;
                if (tick_done) begin
                    led_n   = 8'h01;
                    dir_n   = 1'b0;
                    state_n = RUN;
                end
            end
            RUN: begin
                tick_cnt_n = tick_done ? '0 : tick_cnt + 1'b1;
                if (tick_done) begin
                    led_n = shifted;
                    dir_n = shifted == 8'h80 ? 1'b1 : shifted == 8'h01 ? 1'b0 : dir;
                end
            end
            default: begin
                state_n    = BOOT;
                led_n      = 8'h00;
                boot_cnt_n = '0;
                tick_cnt_n = '0;
                dir_n      = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_microblaze_soc.sv
// tb_microblaze_soc: random reset stimulus against an edge-count model of the boot/lamp/chase sequence
`timescale 1ns/1ps
module tb_microblaze_soc;
    logic clk = 1'b0;
    logic reset_ = 1'b1;
    logic [7:0] led, led_s;
    int n = 0;
    bit valid = 1'b0;
    int cmp = 0;
    int err = 0;
    bit found;
    int lit_n [9] = '{15, 16, 79, 80, 144, 528, 592, 976, 1040};
    logic [7:0] lit_v [9] = '{8'h00, 8'hff, 8'hff, 8'h01, 8'h02, 8'h80, 8'h40, 8'h01, 8'h02};
    int sml_n [6] = '{1, 2, 4, 6, 18, 20};
    logic [7:0] sml_v [6] = '{8'h00, 8'hff, 8'h01, 8'h02, 8'h80, 8'h40};

    always #31.25 clk = ~clk;

    microblaze_soc dut (.clk(clk), .reset_(reset_), .led(led));
    microblaze_soc #(.BOOT_CYCLES(2), .TICK_CYCLES(2)) dut_s (.clk(clk), .reset_(reset_), .led(led_s));

    // expected LED value after e reset-free edges: dark, lamp test, then a 14-step bounce
    function automatic logic [7:0] model(input int e, input int b, input int t);
        int p;
        if (e < b) return 8'h00;
        if (e < b + t) return 8'hff;
        p = ((e - b - t) / t) % 14;
        return p <= 7 ? 8'h01 << p : 8'h01 << (14 - p);
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        cmp++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s edge=%0d actual=%h required=%h", name, n, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (reset_) begin
            n <= 0;
            valid <= 1'b1;
        end else n <= n + 1;
    end

    always @(negedge clk) begin
        if (valid) begin
            check("led", led, model(n, 16, 64));
            check("led_small", led_s, model(n, 2, 2));
            if (n >= 80) check("onehot", 8'($countones(led)), 8'd1);
            if (n >= 4) check("onehot_small", 8'($countones(led_s)), 8'd1);
            foreach (lit_n[i]) if (n == lit_n[i]) check("literal", led, lit_v[i]);
            foreach (sml_n[i]) if (n == sml_n[i]) check("literal_small", led_s, sml_v[i]);
        end
    end

    initial begin
        reset_ = 1'b1;
        repeat (4) @(negedge clk);
        reset_ = 1'b0;
        repeat (1100) @(negedge clk);
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge clk);
            if (led == 8'h08) found = 1'b1;
        end
        if (!found) begin
            cmp++;
            err++;
            $display("FAIL wait_led08 actual=%h required=08", led);
        end
        reset_ = 1'b1;
        @(negedge clk);
        reset_ = 1'b0;
        repeat (200) @(negedge clk);
        for (int r = 0; r < 6; r++) begin
            reset_ = 1'b1;
            repeat ($urandom_range(1, 5)) @(negedge clk);
            reset_ = 1'b0;
            repeat ($urandom_range(10, 1500)) @(negedge clk);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
        $finish;
    end
endmodule
